// File: rtl/acc_core_pkg.sv
// acc_core_pkg: shared definitions for the parametrised accumulator core.
//   - opcode values (upper four bits of an instruction word)
//   - unary sub-codes (carried in the index field of opcode 0x0)
//   - controller state type
package acc_core_pkg;

  localparam logic [3:0] OP_UNARY = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_CMP   = 4'h7;
  localparam logic [3:0] OP_BRC   = 4'h8;
  localparam logic [3:0] OP_LDA   = 4'h9;
  localparam logic [3:0] OP_STA   = 4'hA;
  localparam logic [3:0] OP_JMP   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int U_LSL = 1;
  localparam int U_LSR = 2;
  localparam int U_ROR = 3;
  localparam int U_ROL = 4;
  localparam int U_ASR = 5;
  localparam int U_INC = 6;
  localparam int U_DEC = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DIV  = 2'd2,
    S_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock, W clocks.
//   i_clk, i_rst     shared clock / synchronous active-high reset
//   i_start          load dividend/divisor and begin
//   i_dividend/i_divisor  operands, sampled on i_start
//   o_done           high during the final step; o_quotient/o_remainder
//                    carry that step's result in the same cycle
//   o_dz             latched divisor is zero (quotient all ones,
//                    remainder = dividend falls out of the algorithm)
module seq_divider #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_done,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder,
  output logic         o_dz
);

  localparam int CW = $clog2(W + 1);

  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvs;

  logic [W:0]    w_trial;
  logic          w_fits;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_quo_nxt;

  // Shift the next dividend bit into the partial remainder and try a
  // subtract; a clear top bit means the divisor fit.
  assign w_trial   = {r_rem, r_quo[W-1]} - {1'b0, r_dvs};
  assign w_fits    = ~w_trial[W];
  assign w_rem_nxt = w_fits ? w_trial[W-1:0] : {r_rem[W-2:0], r_quo[W-1]};
  assign w_quo_nxt = {r_quo[W-2:0], w_fits};

  // Results are presented combinationally on the last step so the caller
  // can write back on the same edge, keeping latency at exactly W cycles.
  assign o_done      = r_active && (r_cnt == CW'(1));
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;
  assign o_dz        = (r_dvs == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= CW'(W);
      r_rem    <= '0;
      r_quo    <= i_dividend;
      r_dvs    <= i_divisor;
    end else if (r_active) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/acc_core_param.sv
// acc_core_param: multi-cycle accumulator processor.
//   main_clk, rst        clock / synchronous active-high reset
//   start                pulse: run from pc=0 (accepted in IDLE/HALT)
//   prog_we/addr/data    instruction-memory write port (IDLE/HALT only)
//   dbg_idx, dbg_data    combinational register-file read
//   acc, ext, cb         accumulator, extension (MUL high / DIV rem), flag
//   pc                   current instruction address
//   busy, halted         registered state decodes (RUN|DIV, HALT)
//   div_zero             sticky divide-by-zero flag
module acc_core_param
  import acc_core_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 4,
  parameter int INSTR_W = 4 + IDX_W
) (
  input  logic               main_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               prog_we,
  input  logic [IDX_W-1:0]   prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [IDX_W-1:0]   dbg_idx,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [DATA_W-1:0]  acc,
  output logic [DATA_W-1:0]  ext,
  output logic               cb,
  output logic [IDX_W-1:0]   pc,
  output logic               busy,
  output logic               halted,
  output logic               div_zero
);

  localparam int NREG = 2 ** IDX_W;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_acc, r_ext;
  logic                r_cb, r_dz, r_busy, r_halted;
  logic [IDX_W-1:0]    r_pc;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [INSTR_W-1:0]  r_imem [NREG];

  logic [INSTR_W-1:0]  w_instr;
  logic [3:0]          w_op;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_r;
  logic [DATA_W:0]     w_sum, w_inc;
  logic [2*DATA_W-1:0] w_prod;

  logic [DATA_W-1:0]   w_acc_nxt, w_ext_nxt;
  logic                w_cb_nxt, w_dz_nxt;
  logic [IDX_W-1:0]    w_pc_nxt;
  logic                w_reg_we, w_imem_we, w_div_start;

  logic                w_div_done, w_div_dz;
  logic [DATA_W-1:0]   w_div_q, w_div_r;

  assign w_instr = r_imem[r_pc];
  assign w_op    = w_instr[INSTR_W-1:IDX_W];
  assign w_idx   = w_instr[IDX_W-1:0];
  assign w_r     = r_regs[w_idx];
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_r};
  assign w_inc   = {1'b0, r_acc} + (DATA_W+1)'(1);
  assign w_prod  = {{DATA_W{1'b0}}, r_acc} * {{DATA_W{1'b0}}, w_r};

  seq_divider #(.W(DATA_W)) u_div (
    .i_clk       (main_clk),
    .i_rst       (rst),
    .i_start     (w_div_start),
    .i_dividend  (r_acc),
    .i_divisor   (w_r),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r),
    .o_dz        (w_div_dz)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ext_nxt   = r_ext;
    w_cb_nxt    = r_cb;
    w_pc_nxt    = r_pc;
    w_dz_nxt    = r_dz;
    w_reg_we    = 1'b0;
    w_imem_we   = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        w_imem_we = prog_we;
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
          w_acc_nxt   = '0;
          w_ext_nxt   = '0;
          w_cb_nxt    = 1'b0;
          w_dz_nxt    = 1'b0;
        end
      end
      S_RUN: begin
        w_pc_nxt = r_pc + IDX_W'(1);
        case (w_op)
          OP_UNARY: begin
            case (w_idx)
              IDX_W'(U_LSL): w_acc_nxt = r_acc << 1;
              IDX_W'(U_LSR): w_acc_nxt = r_acc >> 1;
              IDX_W'(U_ROR): w_acc_nxt = {r_acc[0], r_acc[DATA_W-1:1]};
              IDX_W'(U_ROL): w_acc_nxt = {r_acc[DATA_W-2:0], r_acc[DATA_W-1]};
              IDX_W'(U_ASR): w_acc_nxt = {r_acc[DATA_W-1], r_acc[DATA_W-1:1]};
              IDX_W'(U_INC): {w_cb_nxt, w_acc_nxt} = w_inc;
              IDX_W'(U_DEC): begin
                w_acc_nxt = r_acc - DATA_W'(1);
                w_cb_nxt  = (r_acc == '0);
              end
              default: ;
            endcase
          end
          OP_ADD: {w_cb_nxt, w_acc_nxt} = w_sum;
          OP_SUB: begin
            w_acc_nxt = r_acc - w_r;
            w_cb_nxt  = (r_acc < w_r);
          end
          OP_MUL: {w_ext_nxt, w_acc_nxt} = w_prod;
          OP_DIV: begin
            w_div_start = 1'b1;
            w_pc_nxt    = r_pc;
            w_state_nxt = S_DIV;
          end
          OP_AND: w_acc_nxt = r_acc & w_r;
          OP_XOR: w_acc_nxt = r_acc ^ w_r;
          OP_CMP: w_cb_nxt  = (r_acc >= w_r);
          OP_BRC: if (r_cb) w_pc_nxt = w_idx;
          OP_LDA: w_acc_nxt = w_r;
          OP_STA: w_reg_we  = 1'b1;
          OP_JMP: w_pc_nxt  = w_idx;
          OP_HALT: begin
            w_pc_nxt    = r_pc;
            w_state_nxt = S_HALT;
          end
          default: ;
        endcase
      end
      S_DIV: begin
        if (w_div_done) begin
          w_acc_nxt   = w_div_q;
          w_ext_nxt   = w_div_r;
          w_dz_nxt    = r_dz | w_div_dz;
          w_pc_nxt    = r_pc + IDX_W'(1);
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_ext    <= '0;
      r_cb     <= 1'b0;
      r_dz     <= 1'b0;
      r_pc     <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= DATA_W'(i);
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_ext    <= w_ext_nxt;
      r_cb     <= w_cb_nxt;
      r_dz     <= w_dz_nxt;
      r_pc     <= w_pc_nxt;
      r_busy   <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DIV);
      r_halted <= (w_state_nxt == S_HALT);
      if (w_reg_we) r_regs[w_idx] <= r_acc;
    end
  end

  // Instruction memory survives reset; only the write is suppressed by it.
  always_ff @(posedge main_clk) begin
    if (!rst && w_imem_we) r_imem[prog_addr] <= prog_data;
  end

  assign dbg_data = r_regs[dbg_idx];
  assign acc      = r_acc;
  assign ext      = r_ext;
  assign cb       = r_cb;
  assign pc       = r_pc;
  assign busy     = r_busy;
  assign halted   = r_halted;
  assign div_zero = r_dz;

endmodule
